// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: pixel counters, DE/HSYNC/VSYNC, line/frame strobes
// and a frame counter, with flags delayed to match a pixel source of known latency.
module video_timing_gen #(
  parameter int CNT_W      = 12,
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int HS_POL     = 1,
  parameter int VS_POL     = 1,
  parameter int PIPE_DELAY = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             de,
  output logic             hsync,
  output logic             vsync,
  output logic             line_start,
  output logic             frame_start,
  output logic [15:0]      frame_count,
  output logic             busy
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_DE_END   = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_DE_END   = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] H_HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] V_VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic HS_INV = (HS_POL == 0);
  localparam logic VS_INV = (VS_POL == 0);

  // Flag vector bit positions inside the delay line
  localparam int F_DE = 0;
  localparam int F_HS = 1;
  localparam int F_VS = 2;
  localparam int F_LS = 3;
  localparam int F_FS = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic       running;
  logic       line_end;
  logic       frame_end;
  logic [4:0] flags_nxt;
  logic [4:0] pipe [0:PIPE_DELAY];

  assign running   = (state != IDLE);
  assign line_end  = (x == H_LAST);
  assign frame_end = running && line_end && (y == V_LAST);
  assign busy      = running;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Enable changes only redirect the FSM; the raster keeps counting until a frame boundary
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (enable) state_nxt = RUN;
      end
      RUN: begin
        if (frame_end)   state_nxt = enable ? RUN : IDLE;
        else if (!enable) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (frame_end)   state_nxt = enable ? RUN : IDLE;
        else if (enable) state_nxt = RUN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
    end else if (!running) begin
      x <= '0;
      y <= '0;
    end else if (line_end) begin
      x <= '0;
      y <= (y == V_LAST) ? '0 : y + 1'b1;
    end else begin
      x <= x + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_count <= '0;
    end else if (running && (x == '0) && (y == '0)) begin
      frame_count <= frame_count + 16'd1;
    end
  end

  always_comb begin
    flags_nxt = '0;
    if (running) begin
      flags_nxt[F_DE] = (x < H_DE_END) && (y < V_DE_END);
      flags_nxt[F_HS] = (x >= H_HS_START) && (x < H_HS_END);
      flags_nxt[F_VS] = (y >= V_VS_START) && (y < V_VS_END);
      flags_nxt[F_LS] = (x == '0);
      flags_nxt[F_FS] = (x == '0) && (y == '0);
    end
  end

  // Keeps shifting while idle so the last frame's trailing flags drain out as zeros
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= PIPE_DELAY; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= flags_nxt;
      for (int i = 1; i <= PIPE_DELAY; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign de          = pipe[PIPE_DELAY][F_DE];
  assign hsync       = pipe[PIPE_DELAY][F_HS] ^ HS_INV;
  assign vsync       = pipe[PIPE_DELAY][F_VS] ^ VS_INV;
  assign line_start  = pipe[PIPE_DELAY][F_LS];
  assign frame_start = pipe[PIPE_DELAY][F_FS];

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: two small-raster instances (default polarity/no delay, and
// inverted polarity with 3 extra delay stages) checked every clock against a position model.
module tb_video_timing_gen;

  localparam int CW   = 8;
  localparam int HA   = 8;
  localparam int HFP  = 2;
  localparam int HSW  = 3;
  localparam int HBP  = 3;
  localparam int VA   = 6;
  localparam int VFP  = 1;
  localparam int VSW  = 2;
  localparam int VBP  = 2;
  localparam int HT   = HA + HFP + HSW + HBP;
  localparam int VT   = VA + VFP + VSW + VBP;
  localparam int TOT  = HT * VT;
  localparam int PD_B = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic enable = 1'b0;

  logic [CW-1:0] a_x, a_y, b_x, b_y;
  logic a_de, a_hs, a_vs, a_ls, a_fs, a_busy;
  logic b_de, b_hs, b_vs, b_ls, b_fs, b_busy;
  logic [15:0] a_fc, b_fc;

  video_timing_gen #(
    .CNT_W(CW), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HS_POL(1), .VS_POL(1), .PIPE_DELAY(0)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .enable(enable), .x(a_x), .y(a_y),
    .de(a_de), .hsync(a_hs), .vsync(a_vs), .line_start(a_ls), .frame_start(a_fs),
    .frame_count(a_fc), .busy(a_busy)
  );

  video_timing_gen #(
    .CNT_W(CW), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HS_POL(0), .VS_POL(0), .PIPE_DELAY(PD_B)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(enable), .x(b_x), .y(b_y),
    .de(b_de), .hsync(b_hs), .vsync(b_vs), .line_start(b_ls), .frame_start(b_fs),
    .frame_count(b_fc), .busy(b_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: whether the raster is running, linear pixel position within the frame,
  // completed-start count, and the history of flag vectors {fs,ls,vs,hs,de} per clock
  bit          m_run;
  int          m_pos;
  logic [15:0] m_fc;
  logic [4:0]  hist [0:15];

  function automatic logic [4:0] flags_of(int pos);
    int px;
    int py;
    logic [4:0] f;
    px = pos % HT;
    py = pos / HT;
    f[0] = (px < HA) && (py < VA);
    f[1] = (px >= HA + HFP) && (px < HA + HFP + HSW);
    f[2] = (py >= VA + VFP) && (py < VA + VFP + VSW);
    f[3] = (px == 0);
    f[4] = (pos == 0);
    return f;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h pos=%0d", tag, obs, exp, m_pos);
    end
  endtask

  task automatic model_reset();
    m_run = 1'b0;
    m_pos = 0;
    m_fc  = '0;
    for (int i = 0; i < 16; i++) hist[i] = '0;
  endtask

  task automatic check_all();
    logic [4:0] fa;
    logic [4:0] fb;
    fa = hist[0];
    fb = hist[PD_B];
    check_output("a_x", 32'(a_x), 32'(m_pos % HT));
    check_output("a_y", 32'(a_y), 32'(m_pos / HT));
    check_output("a_busy", 32'(a_busy), 32'(m_run));
    check_output("a_frame_count", 32'(a_fc), 32'(m_fc));
    check_output("a_de", 32'(a_de), 32'(fa[0]));
    check_output("a_hsync", 32'(a_hs), 32'(fa[1]));
    check_output("a_vsync", 32'(a_vs), 32'(fa[2]));
    check_output("a_line_start", 32'(a_ls), 32'(fa[3]));
    check_output("a_frame_start", 32'(a_fs), 32'(fa[4]));
    check_output("b_x", 32'(b_x), 32'(m_pos % HT));
    check_output("b_y", 32'(b_y), 32'(m_pos / HT));
    check_output("b_busy", 32'(b_busy), 32'(m_run));
    check_output("b_frame_count", 32'(b_fc), 32'(m_fc));
    check_output("b_de", 32'(b_de), 32'(fb[0]));
    check_output("b_hsync", 32'(b_hs), 32'(!fb[1]));
    check_output("b_vsync", 32'(b_vs), 32'(!fb[2]));
    check_output("b_line_start", 32'(b_ls), 32'(fb[3]));
    check_output("b_frame_start", 32'(b_fs), 32'(fb[4]));
  endtask

  // One clock: advance the model with pre-edge state, then check 1 time unit later
  task automatic step();
    @(posedge clk);
    if (rst_n) begin
      for (int i = 15; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = m_run ? flags_of(m_pos) : 5'd0;
      if (m_run) begin
        if (m_pos == 0) m_fc = m_fc + 16'd1;
        if (m_pos == TOT - 1 && !enable) m_run = 1'b0;
        m_pos = (m_pos + 1) % TOT;
      end else if (enable) begin
        m_run = 1'b1;
      end
    end
    #1;
    check_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_until(input int target);
    int n;
    n = 0;
    while ((m_pos != target || !m_run) && n < 2 * TOT + 4) begin
      step();
      n++;
    end
    checks++;
    assert (n < 2 * TOT + 4) else begin
      errors++;
      $error("[TB] FAIL run_until observed=timeout expected=pos%0d", target);
    end
  endtask

  initial begin
    model_reset();
    #2 rst_n = 1'b0;
    #1 check_all();
    steps(3);

    // Continuous run from reset release: two full frames and a bit
    rst_n  = 1'b1;
    enable = 1'b1;
    steps(2 * TOT + 20);

    // Drop mid-frame, raise again before the frame ends
    run_until(2 * HT + 3);
    enable = 1'b0;
    run_until(4 * HT + 5);
    enable = 1'b1;
    steps(TOT);

    // Drop mid-frame and hold low: drain to end, go idle, then restart
    run_until(20);
    enable = 1'b0;
    steps(TOT + 10);
    enable = 1'b1;
    steps(5);

    // Drop exactly on the last pixel
    run_until(TOT - 1);
    enable = 1'b0;
    steps(8);
    enable = 1'b1;
    steps(3);

    // Drop one pixel before the end, re-raise on the last pixel
    run_until(TOT - 2);
    enable = 1'b0;
    step();
    enable = 1'b1;
    steps(6);

    // Random enable toggling
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 19) == 0) enable = ~enable;
      step();
    end

    // Asynchronous reset mid-frame
    enable = 1'b1;
    run_until(5 * HT + 8);
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all();
    steps(3);
    rst_n = 1'b1;
    steps(TOT + 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
